// File: rtl/tc_io_in_cond.sv
// Pad-to-core input conditioner: per-lane 2-flop synchroniser, optional
// debounce filter, rise/fall edge detection and sticky interrupt-pending bits.
module tc_io_in_cond #(
    parameter int NUM_PINS = 4,
    parameter int DB_W     = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_PINS-1:0] p2c_i,
    input  logic [NUM_PINS-1:0] filt_en_i,
    input  logic [DB_W-1:0]     db_thresh_i,
    input  logic [NUM_PINS-1:0] rise_en_i,
    input  logic [NUM_PINS-1:0] fall_en_i,
    input  logic [NUM_PINS-1:0] irq_clr_i,
    input  logic [NUM_PINS-1:0] irq_mask_i,
    output logic [NUM_PINS-1:0] pin_o,
    output logic [NUM_PINS-1:0] rise_o,
    output logic [NUM_PINS-1:0] fall_o,
    output logic [NUM_PINS-1:0] irq_pend_o,
    output logic                irq_o
);

    logic [NUM_PINS-1:0] r_s1;
    logic [NUM_PINS-1:0] r_s2;
    logic [NUM_PINS-1:0] r_st;
    logic [NUM_PINS-1:0] r_st_q;
    logic [NUM_PINS-1:0] r_pend;
    logic [DB_W-1:0]     r_cnt [NUM_PINS];

    logic                w_thr_zero;
    logic [DB_W:0]       w_cnt_inc [NUM_PINS];
    logic [NUM_PINS-1:0] w_rise;
    logic [NUM_PINS-1:0] w_fall;
    logic [NUM_PINS-1:0] w_set;

    assign w_thr_zero = (db_thresh_i == '0);

    // Count increment carried one bit wider so the compare never sees a wrap.
    always_comb begin
        for (int k = 0; k < NUM_PINS; k++) begin
            w_cnt_inc[k] = {1'b0, r_cnt[k]} + {{DB_W{1'b0}}, 1'b1};
        end
    end

    // Two-flop synchroniser for the asynchronous pad levels.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= p2c_i;
            r_s2 <= r_s1;
        end
    end

    // Per-lane debounce: the level only moves after db_thresh_i consecutive mismatches.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_st <= '0;
            for (int k = 0; k < NUM_PINS; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_PINS; k++) begin
                if (!filt_en_i[k] || w_thr_zero) begin
                    r_st[k]  <= r_s2[k];
                    r_cnt[k] <= '0;
                end else if (r_s2[k] == r_st[k]) begin
                    r_cnt[k] <= '0;
                end else if (w_cnt_inc[k] >= {1'b0, db_thresh_i}) begin
                    r_st[k]  <= r_s2[k];
                    r_cnt[k] <= '0;
                end else begin
                    r_cnt[k] <= w_cnt_inc[k][DB_W-1:0];
                end
            end
        end
    end

    // Delayed copy of the conditioned level for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_st_q <= '0;
        end else begin
            r_st_q <= r_st;
        end
    end

    assign w_rise = r_st & ~r_st_q;
    assign w_fall = ~r_st & r_st_q;
    assign w_set  = (w_rise & rise_en_i) | (w_fall & fall_en_i);

    // Sticky pending bits; a new edge wins over a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_set | (r_pend & ~irq_clr_i);
        end
    end

    assign pin_o      = r_st;
    assign rise_o     = w_rise;
    assign fall_o     = w_fall;
    assign irq_pend_o = r_pend;
    assign irq_o      = |(r_pend & irq_mask_i);

endmodule

// File: tb/tb_tc_io_in_cond.sv
// Self-checking bench for tc_io_in_cond: cycle-by-cycle model comparison
// plus hand-computed checkpoints along a directed stimulus sequence.
module tb_tc_io_in_cond;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  p2c_i;
    logic [3:0]  filt_en_i;
    logic [15:0] db_thresh_i;
    logic [3:0]  rise_en_i;
    logic [3:0]  fall_en_i;
    logic [3:0]  irq_clr_i;
    logic [3:0]  irq_mask_i;
    logic [3:0]  pin_o;
    logic [3:0]  rise_o;
    logic [3:0]  fall_o;
    logic [3:0]  irq_pend_o;
    logic        irq_o;

    int n_chk = 0;
    int n_err = 0;

    tc_io_in_cond #(.NUM_PINS(4), .DB_W(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .p2c_i       (p2c_i),
        .filt_en_i   (filt_en_i),
        .db_thresh_i (db_thresh_i),
        .rise_en_i   (rise_en_i),
        .fall_en_i   (fall_en_i),
        .irq_clr_i   (irq_clr_i),
        .irq_mask_i  (irq_mask_i),
        .pin_o       (pin_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .irq_pend_o  (irq_pend_o),
        .irq_o       (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the pad level seen by the filter is the pad value applied two
    // clocks earlier (zero until two clocks have passed since reset). Each
    // filtered lane counts how long that level has disagreed with the pin.
    logic [3:0] pad_hist [2];
    int         since_rst;
    logic [3:0] m_pin, m_pin_prev, m_pend;
    int         m_run [4];

    always @(posedge clk_i) begin
        logic [3:0] synced;
        logic [3:0] set_v;
        if (rst_i) begin
            since_rst   = 0;
            pad_hist[0] = '0;
            pad_hist[1] = '0;
            m_pin       = '0;
            m_pin_prev  = '0;
            m_pend      = '0;
            for (int k = 0; k < 4; k++) m_run[k] = 0;
        end else begin
            synced = (since_rst >= 2) ? pad_hist[1] : 4'h0;
            set_v  = ((m_pin & ~m_pin_prev) & rise_en_i) | ((~m_pin & m_pin_prev) & fall_en_i);
            m_pend = set_v | (m_pend & ~irq_clr_i);
            m_pin_prev = m_pin;
            for (int k = 0; k < 4; k++) begin
                if (!filt_en_i[k] || db_thresh_i == 16'd0) begin
                    m_pin[k] = synced[k];
                    m_run[k] = 0;
                end else if (synced[k] == m_pin[k]) begin
                    m_run[k] = 0;
                end else begin
                    m_run[k] = m_run[k] + 1;
                    if (m_run[k] >= int'(db_thresh_i)) begin
                        m_pin[k] = synced[k];
                        m_run[k] = 0;
                    end
                end
            end
            pad_hist[1] = pad_hist[0];
            pad_hist[0] = p2c_i;
            since_rst++;
        end
    end

    // Compare every cycle, just after the clock edge has settled.
    always @(posedge clk_i) begin
        #1;
        chk("pin_o",      {28'd0, pin_o},      {28'd0, m_pin});
        chk("rise_o",     {28'd0, rise_o},     {28'd0, m_pin & ~m_pin_prev});
        chk("fall_o",     {28'd0, fall_o},     {28'd0, ~m_pin & m_pin_prev});
        chk("irq_pend_o", {28'd0, irq_pend_o}, {28'd0, m_pend});
        chk("irq_o",      {31'd0, irq_o},      {31'd0, |(m_pend & irq_mask_i)});
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1; p2c_i = 4'hF; filt_en_i = 4'h0; db_thresh_i = 16'd0;
        rise_en_i = 4'h0; fall_en_i = 4'h0; irq_clr_i = 4'h0; irq_mask_i = 4'h0;

        // Reset held 3 cycles with all pads high
        wait_n(3);
        chk("lit_reset_pin", {28'd0, pin_o}, 32'h0);
        chk("lit_reset_rise", {28'd0, rise_o}, 32'h0);
        rst_i = 1'b0;
        wait_n(2);
        chk("lit_rel_pin_c2", {28'd0, pin_o}, 32'h0);
        wait_n(1);
        chk("lit_rel_pin_c3", {28'd0, pin_o}, 32'hF);
        chk("lit_rel_rise_c3", {28'd0, rise_o}, 32'hF);
        wait_n(1);
        chk("lit_rel_rise_c4", {28'd0, rise_o}, 32'h0);

        // Bypass latency on lane 0
        p2c_i = 4'hE;
        wait_n(2);
        chk("lit_byp_fall_c2", {28'd0, fall_o}, 32'h0);
        wait_n(1);
        chk("lit_byp_fall_c3", {28'd0, fall_o}, 32'h1);
        chk("lit_byp_pin_c3", {28'd0, pin_o}, 32'hE);
        p2c_i = 4'hF;
        wait_n(3);
        chk("lit_byp_rise_c3", {28'd0, rise_o}, 32'h1);
        wait_n(1);
        chk("lit_byp_rise_c4", {28'd0, rise_o}, 32'h0);

        // Debounce, threshold 5
        p2c_i = 4'h0;
        wait_n(5);
        filt_en_i = 4'hF; db_thresh_i = 16'd5;
        p2c_i = 4'h2;
        wait_n(4);
        p2c_i = 4'h0;
        wait_n(10);
        chk("lit_glitch_pin", {28'd0, pin_o}, 32'h0);
        p2c_i = 4'h2;
        wait_n(6);
        chk("lit_db_pin_c6", {28'd0, pin_o}, 32'h0);
        wait_n(1);
        chk("lit_db_pin_c7", {28'd0, pin_o}, 32'h2);
        chk("lit_db_rise_c7", {28'd0, rise_o}, 32'h2);
        p2c_i = 4'h0;
        wait_n(10);
        p2c_i = 4'h2;
        wait_n(3);
        p2c_i = 4'h0;
        wait_n(1);
        p2c_i = 4'h2;
        wait_n(6);
        chk("lit_drop_pin_c10", {28'd0, pin_o}, 32'h0);
        wait_n(1);
        chk("lit_drop_pin_c11", {28'd0, pin_o}, 32'h2);
        p2c_i = 4'h0;
        wait_n(10);
        filt_en_i = 4'h0;

        // Interrupt on lane 2, rising only
        rise_en_i = 4'h4; irq_mask_i = 4'h4;
        p2c_i = 4'h4;
        wait_n(3);
        chk("lit_irq_rise", {28'd0, rise_o}, 32'h4);
        chk("lit_irq_pend_early", {28'd0, irq_pend_o}, 32'h0);
        wait_n(1);
        chk("lit_irq_pend", {28'd0, irq_pend_o}, 32'h4);
        chk("lit_irq_o", {31'd0, irq_o}, 32'h1);
        p2c_i = 4'h0;
        wait_n(5);
        chk("lit_irq_fall_nochg", {28'd0, irq_pend_o}, 32'h4);
        irq_clr_i = 4'h4;
        wait_n(1);
        irq_clr_i = 4'h0;
        chk("lit_irq_clr_pend", {28'd0, irq_pend_o}, 32'h0);
        chk("lit_irq_clr_o", {31'd0, irq_o}, 32'h0);
        p2c_i = 4'h4;
        wait_n(4);
        chk("lit_irq_pend2", {28'd0, irq_pend_o}, 32'h4);
        irq_mask_i = 4'h0;
        #1;
        chk("lit_mask_irq_o", {31'd0, irq_o}, 32'h0);
        chk("lit_mask_pend", {28'd0, irq_pend_o}, 32'h4);

        // Set/clear collision on lane 3
        rise_en_i = 4'hC;
        p2c_i = 4'hC;
        wait_n(3);
        chk("lit_coll_rise", {28'd0, rise_o}, 32'h8);
        irq_clr_i = 4'h8;
        wait_n(1);
        irq_clr_i = 4'h0;
        chk("lit_coll_pend", {27'd0, irq_pend_o[3]}, 32'h1);

        // Threshold lowered mid-count on lane 0
        filt_en_i = 4'h1; db_thresh_i = 16'd100;
        p2c_i = 4'hD;
        wait_n(52);
        chk("lit_thr_pin_before", {31'd0, pin_o[0]}, 32'h0);
        db_thresh_i = 16'd10;
        wait_n(1);
        chk("lit_thr_pin_after", {31'd0, pin_o[0]}, 32'h1);

        // Reset in the middle of a count
        db_thresh_i = 16'd100; irq_mask_i = 4'hF;
        p2c_i = 4'hC;
        wait_n(20);
        rst_i = 1'b1;
        wait_n(1);
        chk("lit_mrst_pin", {28'd0, pin_o}, 32'h0);
        chk("lit_mrst_pend", {28'd0, irq_pend_o}, 32'h0);
        chk("lit_mrst_irq", {31'd0, irq_o}, 32'h0);
        rst_i = 1'b0;
        wait_n(3);
        chk("lit_mrst_after_pin", {28'd0, pin_o}, 32'hC);
        chk("lit_mrst_after_rise", {28'd0, rise_o}, 32'hC);
        wait_n(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tc_io_in_cond.md
Name: tc_io_in_cond

Overview:
Pad-to-core input conditioner for the p2c outputs of the tri-state IO pads, covering the receive direction of each pin. Per lane it provides:
- a 2-flop synchroniser;
- an optional debounce filter;
- rise/fall edge detection;
- sticky interrupt-pending bits.

It sits between the pad ring and the GPIO/peripheral core logic. It is clocked by the system clock derived from the crystal pad.

Parameters:
NUM_PINS, 4, number of independent input lanes.
DB_W, 16, width of the debounce counter and threshold.

Ports:
clk_i  input  1  system clock; all logic is rising-edge.
rst_i  input  1  synchronous active-high reset.
p2c_i  input  NUM_PINS  raw, asynchronous pad input levels.
filt_en_i  input  NUM_PINS  per-lane debounce enable.
db_thresh_i  input  DB_W  stable-cycle count that must elapse before a filtered level changes; shared by all lanes.
rise_en_i  input  NUM_PINS  per-lane rising-edge interrupt enable.
fall_en_i  input  NUM_PINS  per-lane falling-edge interrupt enable.
irq_clr_i  input  NUM_PINS  per-lane pending-clear pulse (write-1-to-clear).
irq_mask_i  input  NUM_PINS  per-lane interrupt output mask (1 = enabled).
pin_o  output  NUM_PINS  conditioned (synchronised, filtered) level.
rise_o  output  NUM_PINS  one-cycle pulse on a 0->1 change of pin_o.
fall_o  output  NUM_PINS  one-cycle pulse on a 1->0 change of pin_o.
irq_pend_o  output  NUM_PINS  sticky pending bits.
irq_o  output  1  OR of (irq_pend_o & irq_mask_i).

Behaviour:
- Reset (synchronous, active-high) clears every register: sync flops, counters, state, delayed state and pending bits.
  - Reset values: pin_o=0, rise_o=0, fall_o=0, irq_pend_o=0, irq_o=0.
  - Reset asserted mid-count discards the count; no edge is reported for the reset itself.
- Sync stage: s1<=p2c_i, s2<=s1. s2 is the synchronised level, 2 cycles behind the pad.
- Per-lane filter. Each lane holds registered state st (drives pin_o) and counter cnt[DB_W].
  - Bypass when filt_en_i[k]=0 or db_thresh_i=0: st<=s2 every cycle and cnt<=0. Pad-to-pin_o latency is 3 cycles.
  - Filter, s2==st: cnt<=0.
  - Filter, s2!=st and cnt+1 >= db_thresh_i: st<=s2, cnt<=0.
  - Filter, s2!=st otherwise: cnt<=cnt+1.
  - Result: st changes after exactly db_thresh_i consecutive mismatching cycles of s2. Pad-to-pin_o latency is 2+db_thresh_i cycles.
  - A single matching cycle restarts the count, so a glitch shorter than db_thresh_i cycles never reaches pin_o.
  - Using >= means lowering db_thresh_i mid-count below the current cnt completes the change on the next mismatching cycle.
  - cnt never wraps: it is bounded by db_thresh_i <= 2^DB_W-1.
- Edge detect: st_q<=st.
  - rise_o = st & ~st_q; fall_o = ~st & st_q.
  - Each pulse is combinational from registers, high for exactly the first cycle pin_o shows the new level.
- Pending, per lane: set = (rise_o & rise_en_i) | (fall_o & fall_en_i).
  - set=1: pend<=1. Set wins over a simultaneous irq_clr_i.
  - irq_clr_i=1 and set=0: pend<=0.
  - Otherwise pend holds.
  - Enables gate only setting; clearing an enable does not clear pend.
- irq_o is combinational: |(irq_pend_o & irq_mask_i). Masking hides a pending bit without clearing it.
- Toggling filt_en_i from 1 to 0 mid-count: the next cycle takes the bypass path (st<=s2, cnt<=0).
- Lanes are fully independent apart from the shared db_thresh_i.

Test Plan:
- Reset: hold rst_i 3 cycles with p2c_i=4'hF. All outputs stay 0 during reset. After release, pin_o=4'hF at cycle 3 with no filter, and rise_o=4'hF pulses for exactly 1 cycle.
- Bypass latency: filt_en_i=0, lane0 0->1 at cycle T -> pin_o[0]=1 at T+3, rise_o[0] high only at T+3. Then 1->0 -> fall_o[0] pulses 3 cycles later.
- Debounce: filt_en_i=1, db_thresh_i=5.
  - 4-cycle high glitch on lane1 -> pin_o[1] stays 0, no rise_o.
  - Steady high -> pin_o[1]=1 exactly 7 cycles after the pad edge.
  - A glitch that drops for 1 cycle at count 3 restarts the count, delaying the change by the dropout plus 5 cycles.
- Interrupt: rise_en_i[2]=1, fall_en_i[2]=0, irq_mask_i[2]=1.
  - Rising edge -> irq_pend_o[2]=1 one cycle after rise_o, and irq_o=1.
  - Falling edge -> no change.
  - irq_clr_i[2] pulse -> pend 0, irq_o 0.
  - Setting irq_mask_i[2]=0 with pend set -> irq_o=0 while irq_pend_o[2] stays 1.
- Set/clear collision: irq_clr_i[3]=1 in the same cycle as an enabled rise_o[3] -> irq_pend_o[3]=1.
- Threshold change: db_thresh_i=100, cnt reaches 50, then db_thresh_i set to 10 -> pin_o updates on the next mismatching cycle. Mid-count reset -> cnt and pin_o return to 0.
